// File: rtl/nv_ram_rwsp_mask_init.sv
// Single-read/single-write-port RAM with per-segment write masks, optional write
// bypass into the output register, read-valid tracking and reset-time zeroing.
module nv_ram_rwsp_mask_init #(
    parameter int DEPTH         = 32,
    parameter int AW            = 5,
    parameter int WIDTH         = 129,
    parameter int MASK_GRAN     = 43,
    parameter int BYPASS        = 1,
    parameter int INIT_ON_RESET = 1,
    parameter int NSEG          = WIDTH / MASK_GRAN
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [NSEG-1:0]  wmask,
    input  logic [WIDTH-1:0] di,
    output logic             init_done,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [0:0]       state;
    logic [AW-1:0]    init_cnt;
    logic [AW-1:0]    ra_d;
    logic             rd_pend;
    logic [WIDTH-1:0] rdata;
    logic             ready;
    logic             wr_ok;
    logic             rd_in_range;
    logic             unused_pd;

    assign unused_pd   = ^pwrbus_ram_pd;
    assign ready       = (state == ST_READY);
    assign wr_ok       = ready && we && ({1'b0, wa} < (AW+1)'(DEPTH));
    assign rd_in_range = ({1'b0, ra_d} < (AW+1)'(DEPTH));

    // Read data seen by the output register; a coincident write to the captured
    // address overrides the stored segments it enables when bypass is built in.
    always_comb begin
        rdata = '0;
        if (rd_in_range) begin
            rdata = mem[ra_d];
        end
        if ((BYPASS != 0) && wr_ok && (wa == ra_d)) begin
            for (int i = 0; i < NSEG; i++) begin
                if (wmask[i]) begin
                    rdata[i*MASK_GRAN +: MASK_GRAN] = di[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NSEG; i++) begin
                if (wmask[i]) begin
                    mem[wa][i*MASK_GRAN +: MASK_GRAN] <= di[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
            init_done <= (INIT_ON_RESET == 0);
            init_cnt  <= '0;
            ra_d      <= '0;
            rd_pend   <= 1'b0;
            dout      <= '0;
            dout_vld  <= 1'b0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == AW'(DEPTH - 1)) begin
                state     <= ST_READY;
                init_done <= 1'b1;
            end
        end else begin
            if (re) begin
                ra_d <= ra;
            end
            if (ore) begin
                dout     <= rdata;
                dout_vld <= rd_pend;
            end
            // A fresh capture on the same edge as a load keeps the read pending.
            if (re) begin
                rd_pend <= 1'b1;
            end else if (ore) begin
                rd_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nv_ram_rwsp_mask_init.sv
// Directed bench: two RAM instances (32-deep with bypass, 20-deep without) share
// stimulus; per-instance expected outputs are listed in a vector table.
module tb_nv_ram_rwsp_mask_init;

    localparam int W = 129;

    typedef struct {
        logic         re;
        logic         ore;
        logic [4:0]   ra;
        logic         we;
        logic [4:0]   wa;
        logic [2:0]   wmask;
        logic [W-1:0] di;
        logic [W-1:0] d1;
        logic         v1;
        logic [W-1:0] d2;
        logic         v2;
    } vec_t;

    logic         clk;
    logic         rstn;
    logic [4:0]   ra;
    logic         re;
    logic         ore;
    logic [4:0]   wa;
    logic         we;
    logic [2:0]   wmask;
    logic [W-1:0] di;
    logic [31:0]  pd;
    logic [W-1:0] dout1;
    logic [W-1:0] dout2;
    logic         vld1;
    logic         vld2;
    logic         done1;
    logic         done2;

    int checks;
    int errors;
    vec_t vecs[$];

    logic [W-1:0] all1;
    logic [W-1:0] pat_p;
    logic [W-1:0] pat_q;
    logic [W-1:0] pat_bd;
    logic [W-1:0] pat_lo;

    nv_ram_rwsp_mask_init #(
        .DEPTH(32), .AW(5), .WIDTH(W), .MASK_GRAN(43), .BYPASS(1), .INIT_ON_RESET(1)
    ) dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .ra(ra), .re(re), .ore(ore), .dout(dout1), .dout_vld(vld1),
        .wa(wa), .we(we), .wmask(wmask), .di(di),
        .init_done(done1), .pwrbus_ram_pd(pd)
    );

    nv_ram_rwsp_mask_init #(
        .DEPTH(20), .AW(5), .WIDTH(W), .MASK_GRAN(43), .BYPASS(0), .INIT_ON_RESET(1)
    ) dut2 (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .ra(ra), .re(re), .ore(ore), .dout(dout2), .dout_vld(vld2),
        .wa(wa), .we(we), .wmask(wmask), .di(di),
        .init_done(done2), .pwrbus_ram_pd(pd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        re = 0; ore = 0; we = 0; ra = '0; wa = '0; wmask = '0; di = '0;
    endtask

    task automatic addVec(input logic r, input logic o, input logic [4:0] a, input logic w,
                          input logic [4:0] b, input logic [2:0] m, input logic [W-1:0] d,
                          input logic [W-1:0] e1, input logic ev1,
                          input logic [W-1:0] e2, input logic ev2);
        vec_t v;
        v.re = r; v.ore = o; v.ra = a; v.we = w; v.wa = b; v.wmask = m; v.di = d;
        v.d1 = e1; v.v1 = ev1; v.d2 = e2; v.v2 = ev2;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        re = v.re; ore = v.ore; ra = v.ra; we = v.we; wa = v.wa; wmask = v.wmask; di = v.di;
        @(posedge clk);
        #1;
    endtask

    // Counts edges after reset release, checking init_done of both instances;
    // optional traffic during the first 15 edges must be ignored.
    task automatic runInit(input int edges, input bit traffic);
        if (traffic) begin
            re = 1; ore = 1; ra = 5'd3; we = 1; wa = 5'd31; wmask = 3'b111; di = all1;
        end
        for (int k = 1; k <= edges; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("init edge%0d done1", k), W'(done1), W'(k >= 32));
            checkOutput($sformatf("init edge%0d done2", k), W'(done2), W'(k >= 20));
            if (k == 15) begin
                checkOutput("init dout1", dout1, '0);
                checkOutput("init vld1", W'(vld1), '0);
                checkOutput("init dout2", dout2, '0);
                checkOutput("init vld2", W'(vld2), '0);
                idleInputs();
            end
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " dout1"}, dout1, '0);
        checkOutput({tag, " vld1"}, W'(vld1), '0);
        checkOutput({tag, " done1"}, W'(done1), '0);
        checkOutput({tag, " dout2"}, dout2, '0);
        checkOutput({tag, " vld2"}, W'(vld2), '0);
        checkOutput({tag, " done2"}, W'(done2), '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pd     = 32'hdead_beef;
        rstn   = 1'b0;
        idleInputs();

        all1   = '1;
        pat_p  = all1;
        pat_p[85:43] = '0;
        pat_q  = '0;
        pat_q[128:86] = '1;
        pat_bd = all1;
        pat_bd[42:0] = 43'h1234;
        pat_lo = W'(43'h1234);

        //       re ore ra   we wa  mask    di      dout1   v1 dout2   v2
        addVec(0, 1, 0,  0, 0,  3'b000, '0,     '0,     0, '0,     0);
        addVec(0, 0, 0,  1, 5,  3'b111, all1,   '0,     0, '0,     0);
        addVec(0, 0, 0,  1, 5,  3'b010, '0,     '0,     0, '0,     0);
        addVec(1, 0, 5,  0, 0,  3'b000, '0,     '0,     0, '0,     0);
        addVec(0, 1, 0,  0, 0,  3'b000, '0,     pat_p,  1, pat_p,  1);
        addVec(0, 0, 0,  0, 0,  3'b000, '0,     pat_p,  1, pat_p,  1);
        addVec(1, 0, 7,  0, 0,  3'b000, '0,     pat_p,  1, pat_p,  1);
        addVec(0, 1, 0,  1, 7,  3'b001, pat_bd, pat_lo, 1, '0,     1);
        addVec(1, 0, 7,  0, 0,  3'b000, '0,     pat_lo, 1, '0,     1);
        addVec(0, 1, 0,  0, 0,  3'b000, '0,     pat_lo, 1, pat_lo, 1);
        addVec(1, 1, 5,  0, 0,  3'b000, '0,     pat_lo, 0, pat_lo, 0);
        addVec(0, 1, 0,  0, 0,  3'b000, '0,     pat_p,  1, pat_p,  1);
        addVec(1, 0, 9,  1, 9,  3'b100, all1,   pat_p,  1, pat_p,  1);
        addVec(0, 1, 0,  0, 0,  3'b000, '0,     pat_q,  1, pat_q,  1);
        addVec(0, 0, 0,  1, 25, 3'b111, all1,   pat_q,  1, pat_q,  1);
        addVec(1, 0, 25, 0, 0,  3'b000, '0,     pat_q,  1, pat_q,  1);
        addVec(0, 1, 0,  0, 0,  3'b000, '0,     all1,   1, '0,     1);
        addVec(1, 0, 5,  0, 0,  3'b000, '0,     all1,   1, '0,     1);
        addVec(0, 1, 0,  0, 0,  3'b000, '0,     pat_p,  1, pat_p,  1);
        addVec(0, 0, 0,  1, 5,  3'b000, '0,     pat_p,  1, pat_p,  1);
        addVec(1, 0, 9,  0, 0,  3'b000, '0,     pat_p,  1, pat_p,  1);
        addVec(0, 1, 0,  0, 0,  3'b000, '0,     pat_q,  1, pat_q,  1);
        addVec(1, 0, 5,  0, 0,  3'b000, '0,     pat_q,  1, pat_q,  1);
        addVec(0, 1, 0,  0, 0,  3'b000, '0,     pat_p,  1, pat_p,  1);

        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        rstn = 1'b1;
        runInit(32, 1'b1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d dout1", i), dout1, vecs[i].d1);
            checkOutput($sformatf("vec%0d vld1", i), W'(vld1), W'(vecs[i].v1));
            checkOutput($sformatf("vec%0d dout2", i), dout2, vecs[i].d2);
            checkOutput($sformatf("vec%0d vld2", i), W'(vld2), W'(vecs[i].v2));
        end
        idleInputs();

        // Reset in the middle of traffic clears outputs without a clock edge.
        rstn = 1'b0;
        #1;
        checkResetState("traffic reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkResetState("mid-init reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        runInit(32, 1'b0);

        // After re-initialisation the previously written entry reads back zero.
        re = 1; ra = 5'd5;
        @(posedge clk);
        #1;
        re = 0; ore = 1;
        @(posedge clk);
        #1;
        ore = 0;
        checkOutput("reinit dout1", dout1, '0);
        checkOutput("reinit vld1", W'(vld1), W'(1));
        checkOutput("reinit dout2", dout2, '0);
        checkOutput("reinit vld2", W'(vld2), W'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
